// File: rtl/multicycle_controller_if.sv
// Instruction-field and datapath-control bundle between the multicycle controller
// (master) and the shared-memory/shared-ALU datapath (slave).
interface multicycle_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags,
               instr_done, illegal
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags,
               instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: fetch/decode/execute/memory/writeback sequencing,
// NZCV flag register and condition-gated architectural writes.
module multicycle_controller #(
    parameter bit EXT_OPS = 1'b0
) (
    input logic                      clk,
    input logic                      reset_n,
    multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH
    } stateT;

    stateT      state;
    stateT      stateNext;
    logic [3:0] flags;
    logic       condexQ;

    logic [3:0] cmd;
    logic       sBit;
    logic       cmdOk;
    logic       arith;
    logic       isCmp;
    logic [2:0] aluDec;
    logic       illegalDec;
    logic       condEx;
    logic       noWrite;
    logic       pcs;

    logic       nextPC;
    logic       irWrite;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       aluOp;
    logic       adrSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       done;
    logic       illegalOut;

    assign cmd  = bus.Funct[4:1];
    assign sBit = bus.Funct[0];

    always_comb begin
        cmdOk  = 1'b1;
        arith  = 1'b0;
        isCmp  = 1'b0;
        aluDec = 3'b000;
        case (cmd)
            4'b0100: begin aluDec = 3'b000; arith = 1'b1; end
            4'b0010: begin aluDec = 3'b001; arith = 1'b1; end
            4'b0000: aluDec = 3'b010;
            4'b1100: aluDec = 3'b011;
            4'b1010: begin aluDec = 3'b001; arith = 1'b1; isCmp = 1'b1; end
            4'b0001: begin aluDec = 3'b100; cmdOk = EXT_OPS; end
            4'b1101: begin aluDec = 3'b101; cmdOk = EXT_OPS; end
            4'b1110: begin aluDec = 3'b110; cmdOk = EXT_OPS; end
            default: cmdOk = 1'b0;
        endcase
    end

    assign illegalDec = (bus.Op == 2'b11) || ((bus.Op == 2'b00) && !cmdOk);

    always_comb begin
        condEx = 1'b1;
        case (bus.Cond)
            4'b0000: condEx = flags[2];
            4'b0001: condEx = ~flags[2];
            4'b0010: condEx = flags[1];
            4'b0011: condEx = ~flags[1];
            4'b0100: condEx = flags[3];
            4'b0101: condEx = ~flags[3];
            4'b0110: condEx = flags[0];
            4'b0111: condEx = ~flags[0];
            4'b1000: condEx = flags[1] & ~flags[2];
            4'b1001: condEx = ~flags[1] | flags[2];
            4'b1010: condEx = (flags[3] == flags[0]);
            4'b1011: condEx = (flags[3] != flags[0]);
            4'b1100: condEx = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condEx = flags[2] | (flags[3] != flags[0]);
            default: condEx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // condexQ is captured once in DECODE and qualifies every write for the rest
    // of the instruction, so later flag changes cannot affect it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            condexQ <= 1'b0;
            flags   <= '0;
        end else begin
            if (state == DECODE) begin
                condexQ <= condEx;
            end
            if ((state == EXECUTER || state == EXECUTEI) && condexQ) begin
                if (sBit) begin
                    flags[3:2] <= bus.ALUFlags[3:2];
                end
                if (sBit && arith) begin
                    flags[1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        stateNext  = state;
        nextPC     = 1'b0;
        irWrite    = 1'b0;
        regW       = 1'b0;
        memW       = 1'b0;
        branch     = 1'b0;
        aluOp      = 1'b0;
        adrSrc     = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        resultSrc  = 2'b00;
        done       = 1'b0;
        illegalOut = 1'b0;
        case (state)
            FETCH: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = 1'b1;
                nextPC    = 1'b1;
                stateNext = DECODE;
            end
            DECODE: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (illegalDec) begin
                    illegalOut = 1'b1;
                    done       = 1'b1;
                    stateNext  = FETCH;
                end else begin
                    case (bus.Op)
                        2'b00:   stateNext = bus.Funct[5] ? EXECUTEI : EXECUTER;
                        2'b01:   stateNext = MEMADR;
                        default: stateNext = BRANCH;
                    endcase
                end
            end
            MEMADR: begin
                aluSrcB   = 2'b01;
                stateNext = sBit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc    = 1'b1;
                stateNext = MEMWB;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regW      = 1'b1;
                done      = 1'b1;
                stateNext = FETCH;
            end
            MEMWRITE: begin
                adrSrc    = 1'b1;
                memW      = 1'b1;
                done      = 1'b1;
                stateNext = FETCH;
            end
            EXECUTER: begin
                aluSrcB   = 2'b00;
                aluOp     = 1'b1;
                stateNext = ALUWB;
            end
            EXECUTEI: begin
                aluSrcB   = 2'b01;
                aluOp     = 1'b1;
                stateNext = ALUWB;
            end
            ALUWB: begin
                regW      = 1'b1;
                done      = 1'b1;
                stateNext = FETCH;
            end
            BRANCH: begin
                aluSrcB   = 2'b01;
                resultSrc = 2'b10;
                branch    = 1'b1;
                done      = 1'b1;
                stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase
    end

    // NoWrite only applies to data-processing CMP; memory Funct bits can alias cmd 1010.
    assign noWrite = isCmp && (bus.Op == 2'b00);
    assign pcs     = branch | (regW & (bus.Rd == 4'b1111));

    assign bus.PCWrite    = reset_n & (nextPC | (pcs & condexQ));
    assign bus.IRWrite    = reset_n & irWrite;
    assign bus.RegWrite   = reset_n & regW & condexQ & ~noWrite;
    assign bus.MemWrite   = reset_n & memW & condexQ;
    assign bus.instr_done = reset_n & done;
    assign bus.illegal    = reset_n & illegalOut;

    assign bus.AdrSrc     = adrSrc;
    assign bus.ALUSrcA    = aluSrcA;
    assign bus.ALUSrcB    = aluSrcB;
    assign bus.ResultSrc  = resultSrc;
    assign bus.ALUControl = aluOp ? aluDec : 3'b000;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Flags      = flags;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: both EXT_OPS variants are driven in turn
// and compared cycle-by-cycle against an instruction-level reference model.
module tb_multicycle_controller;

    typedef enum int {K_DP, K_LDR, K_STR, K_BR, K_ILL} kindT;

    logic       clk = 1'b0;
    logic       rstN0 = 1'b0;
    logic       rstN1 = 1'b0;
    logic [3:0] cond = 4'hE;
    logic [1:0] opS = 2'b00;
    logic [5:0] funct = '0;
    logic [3:0] rdS = '0;
    logic [3:0] aluFlags = '0;

    int         vectors = 0;
    int         miscompares = 0;
    int         instrNo = 0;
    logic [3:0] mFlags [2];

    multicycle_controller_if if0 ();
    multicycle_controller_if if1 ();

    assign if0.Cond = cond;  assign if0.Op = opS;  assign if0.Funct = funct;
    assign if0.Rd = rdS;     assign if0.ALUFlags = aluFlags;
    assign if1.Cond = cond;  assign if1.Op = opS;  assign if1.Funct = funct;
    assign if1.Rd = rdS;     assign if1.ALUFlags = aluFlags;

    multicycle_controller #(.EXT_OPS(1'b0)) dut0 (.clk(clk), .reset_n(rstN0), .bus(if0));
    multicycle_controller #(.EXT_OPS(1'b1)) dut1 (.clk(clk), .reset_n(rstN1), .bus(if1));

    logic [18:0] obs0, obs1;
    assign obs0 = {if0.PCWrite, if0.IRWrite, if0.RegWrite, if0.MemWrite, if0.AdrSrc, if0.ALUSrcA,
                   if0.ResultSrc, if0.ALUSrcB, if0.ImmSrc, if0.RegSrc, if0.ALUControl,
                   if0.instr_done, if0.illegal};
    assign obs1 = {if1.PCWrite, if1.IRWrite, if1.RegWrite, if1.MemWrite, if1.AdrSrc, if1.ALUSrcA,
                   if1.ResultSrc, if1.ALUSrcB, if1.ImmSrc, if1.RegSrc, if1.ALUControl,
                   if1.instr_done, if1.illegal};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit condPass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit supported(input logic [3:0] c, input bit ext);
        return (c inside {4'h4, 4'h2, 4'h0, 4'hC, 4'hA}) || (ext && (c inside {4'h1, 4'hD, 4'hE}));
    endfunction

    function automatic logic [2:0] aluCode(input logic [3:0] c);
        case (c)
            4'h4: return 3'd0;   // ADD
            4'h2: return 3'd1;   // SUB
            4'hA: return 3'd1;   // CMP
            4'h0: return 3'd2;   // AND
            4'hC: return 3'd3;   // ORR
            4'h1: return 3'd4;   // EOR
            4'hD: return 3'd5;   // MOV
            4'hE: return 3'd6;   // BIC
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [18:0] rstExp(input logic [1:0] op);
        return {6'b000001, 2'b10, 2'b10, op, (op == 2'b01), (op == 2'b10), 3'b000, 2'b00};
    endfunction

    // Expected control word for cycle k of an instruction, counted from its FETCH cycle.
    function automatic logic [18:0] expCycle(input int k, input kindT kind, input logic [1:0] op,
                                             input logic [5:0] fn, input bit rd15, input bit cx);
        bit pcw = 0, irw = 0, regw = 0, memw = 0, adr = 0, srcA = 0, done = 0, ill = 0;
        logic [1:0] res = 2'b00, srcB = 2'b00;
        logic [2:0] alu = 3'b000;
        if (k == 0) begin
            pcw = 1; irw = 1; srcA = 1; srcB = 2'b10; res = 2'b10;
        end else if (k == 1) begin
            srcA = 1; srcB = 2'b10; res = 2'b10;
            if (kind == K_ILL) begin ill = 1; done = 1; end
        end else begin
            case (kind)
                K_LDR: begin
                    if (k == 2) srcB = 2'b01;
                    else if (k == 3) adr = 1;
                    else begin res = 2'b01; regw = cx; pcw = cx && rd15; done = 1; end
                end
                K_STR: begin
                    if (k == 2) srcB = 2'b01;
                    else begin adr = 1; memw = cx; done = 1; end
                end
                K_DP: begin
                    if (k == 2) begin
                        srcB = fn[5] ? 2'b01 : 2'b00;
                        alu  = aluCode(fn[4:1]);
                    end else begin
                        regw = cx && (fn[4:1] != 4'hA);
                        pcw  = cx && rd15;
                        done = 1;
                    end
                end
                default: begin
                    srcB = 2'b01; res = 2'b10; pcw = cx; done = 1;
                end
            endcase
        end
        return {pcw, irw, regw, memw, adr, srcA, res, srcB, op, (op == 2'b01), (op == 2'b10),
                alu, done, ill};
    endfunction

    task automatic setRst(input int sel, input logic v);
        if (sel == 1) rstN1 = v;
        else rstN0 = v;
    endtask

    task automatic sampleAndCheck(input int sel, input string tag, input logic [18:0] expCtl,
                                  input logic [3:0] expFlags);
        checkVal({tag, ".ctrl"}, 32'(sel == 1 ? obs1 : obs0), 32'(expCtl));
        checkVal({tag, ".flags"}, 32'(sel == 1 ? if1.Flags : if0.Flags), 32'(expFlags));
    endtask

    // Entered #1 after a posedge with the selected DUT in FETCH; leaves it the same way.
    task automatic runInstr(input int sel, input logic [3:0] c, input logic [1:0] op,
                            input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af,
                            input int abortAt);
        kindT kind;
        int   len;
        bit   cx;
        cond = c; opS = op; funct = fn; rdS = rd; aluFlags = af;
        case (op)
            2'b00:   kind = supported(fn[4:1], sel == 1) ? K_DP : K_ILL;
            2'b01:   kind = fn[0] ? K_LDR : K_STR;
            2'b10:   kind = K_BR;
            default: kind = K_ILL;
        endcase
        case (kind)
            K_LDR:   len = 5;
            K_STR:   len = 4;
            K_DP:    len = 4;
            K_BR:    len = 3;
            default: len = 2;
        endcase
        cx = condPass(c, mFlags[sel]);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            sampleAndCheck(sel, $sformatf("i%0d.c%0d", instrNo, k),
                           expCycle(k, kind, op, fn, rd == 4'hF, cx), mFlags[sel]);
            if (k == abortAt) begin
                #2;
                setRst(sel, 1'b0);
                mFlags[sel] = '0;
                #1;
                sampleAndCheck(sel, $sformatf("i%0d.abort", instrNo), rstExp(op), 4'h0);
                @(posedge clk);
                #1;
                sampleAndCheck(sel, $sformatf("i%0d.abortHold", instrNo), rstExp(op), 4'h0);
                setRst(sel, 1'b1);
                instrNo++;
                return;
            end
            if (kind == K_DP && k == 2 && cx) begin
                if (fn[0]) mFlags[sel][3:2] = af[3:2];
                if (fn[0] && (fn[4:1] inside {4'h4, 4'h2, 4'hA})) mFlags[sel][1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
        instrNo++;
    endtask

    task automatic resetDut(input int sel);
        setRst(sel, 1'b0);
        opS = 2'b00;
        mFlags[sel] = '0;
        @(negedge clk);
        sampleAndCheck(sel, $sformatf("reset%0d", sel), rstExp(2'b00), 4'h0);
        @(posedge clk);
        #1;
        setRst(sel, 1'b1);
    endtask

    task automatic randomInstr(input int sel);
        int         r = $urandom_range(0, 9);
        logic [1:0] op;
        logic [5:0] fn = 6'($urandom);
        logic [3:0] rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        if (r <= 4) op = 2'b00;
        else if (r <= 6) op = 2'b01;
        else if (r <= 8) op = 2'b10;
        else op = 2'b11;
        runInstr(sel, 4'($urandom), op, fn, rd, 4'($urandom), -1);
    endtask

    initial begin
        mFlags[0] = '0;
        mFlags[1] = '0;
        repeat (2) @(posedge clk);

        // Extended-op variant: directed sequence, then random traffic.
        resetDut(1);
        runInstr(1, 4'hE, 2'b00, 6'b100000, 4'd3, 4'b1111, -1);   // AND R3,R3,#0
        runInstr(1, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, -1);   // CMP R2,R3
        checkVal("cmpFlags", 32'(if1.Flags), 32'h4);
        runInstr(1, 4'h1, 2'b00, 6'b101000, 4'd4, 4'b0000, -1);   // ADDNE
        runInstr(1, 4'h0, 2'b00, 6'b101000, 4'd4, 4'b0000, -1);   // ADDEQ
        runInstr(1, 4'hE, 2'b01, 6'b100001, 4'd5, 4'b0000, -1);   // LDR
        runInstr(1, 4'hE, 2'b01, 6'b100000, 4'd5, 4'b0000, -1);   // STR
        runInstr(1, 4'hE, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);   // B
        runInstr(1, 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, -1);   // ADD PC,...
        runInstr(1, 4'hE, 2'b00, 6'b000010, 4'd1, 4'b0000, -1);   // EOR
        runInstr(1, 4'hE, 2'b00, 6'b001001, 4'd2, 4'b1011, -1);   // ADDS sets flags
        runInstr(1, 4'hE, 2'b01, 6'b100001, 4'd6, 4'b0000, 3);    // LDR aborted in MEMREAD
        runInstr(1, 4'hE, 2'b00, 6'b100000, 4'd3, 4'b0000, -1);   // clean restart
        for (int i = 0; i < 200; i++) randomInstr(1);

        // Base variant: extended ops must decode as illegal.
        rstN1 = 1'b0;
        resetDut(0);
        runInstr(0, 4'hE, 2'b00, 6'b000010, 4'd1, 4'b0000, -1);   // EOR -> illegal
        runInstr(0, 4'hE, 2'b00, 6'b011011, 4'd1, 4'b1111, -1);   // MOVS -> illegal
        runInstr(0, 4'hE, 2'b11, 6'b000000, 4'd1, 4'b0000, -1);   // Op=11 -> illegal
        for (int i = 0; i < 200; i++) randomInstr(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequential control unit for the ARM calculator datapath, replacing the single-cycle decoder with a state machine that drives a shared-memory, shared-ALU multicycle datapath. Decodes Op/Funct/Rd/Cond from the instruction register, sequences fetch/decode/execute/memory/writeback, holds the NZCV flag register, and gates all architectural writes by the condition check. A parameter selects a base or extended data-processing command set.

## Interface
- EXT_OPS, 0, 0: ADD/SUB/AND/ORR/CMP only; 1: additionally EOR, BIC, MOV.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S; for memory, bit0 = L)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  N,Z,C,V from ALU, valid in EXECUTE states
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  out  1 each
- ResultSrc, ALUSrcB, ImmSrc, RegSrc  out  2 each
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV(pass B), 110 BIC
- Flags  out  4  current NZCV register
- instr_done  out  1  high on the last cycle of every instruction
- illegal  out  1  high in DECODE for an unsupported encoding

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH→DECODE always. DECODE: Op=00,I=0→EXECUTER; Op=00,I=1→EXECUTEI; Op=01→MEMADR; Op=10→BRANCH; Op=11 or unsupported cmd→FETCH with illegal=1.
- MEMADR→MEMREAD if L=1 else MEMWRITE. MEMREAD→MEMWB. EXECUTER/EXECUTEI→ALUWB. MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH.
- Moore outputs (others 0, ALUControl=000 unless stated): FETCH AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1. DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR ALUSrcA=0, ALUSrcB=01. MEMREAD AdrSrc=1. MEMWB ResultSrc=01, RegW=1. MEMWRITE AdrSrc=1, MemW=1. EXECUTER ALUSrcB=00, ALUOp=1. EXECUTEI ALUSrcB=01, ALUOp=1. ALUWB RegW=1 (NoWrite for CMP). BRANCH ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode (ALUOp=1), cmd=Funct[4:1]: 0100→000, 0010→001, 0000→010, 1100→011, 1010 (CMP)→001 with NoWrite. EXT_OPS=1 adds 0001→100, 1101→101, 1110→110. Any other cmd is unsupported.
- FlagW[1] (N,Z) = S; FlagW[0] (C,V) = S and cmd in {ADD,SUB,CMP}.
- CondEx: full ARM table (EQ..AL; 1111 treated as AL) on Flags; evaluated in DECODE, registered as condex_q, used for the rest of the instruction.
- Gating: RegWrite = RegW & condex_q & ~NoWrite; MemWrite = MemW & condex_q; PCWrite = NextPC | (PCS & condex_q), where PCS = Branch | (RegW & Rd=1111).
- Flags update at the edge leaving EXECUTER/EXECUTEI when condex_q=1, per FlagW bit pair.
- ImmSrc = Op; RegSrc[0] = (Op=10), RegSrc[1] = (Op=01); combinational.
- Condition-failed instructions walk the same state path with all writes suppressed (except FETCH's).

## Timing
- Reset (async assert, sync deassert sampled by clk): state=FETCH, Flags=0000, condex_q=0; while reset_n=0, PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal forced 0; other outputs take FETCH values.
- Latencies including FETCH: LDR 5 cycles; STR, data-proc reg/imm 4; B 3; illegal 2.
- Reset mid-instruction: immediate return to FETCH, no write completes, Flags cleared.
- Flags written in cycle N are visible to CondEx in DECODE of the next instruction (no hazard).

## Test plan
- Reset then AND R3,R3,#0 (Cond=1110, Op=00, Funct=100000): FETCH, DECODE, EXECUTEI, ALUWB; ALUControl=010 in EXECUTEI; RegWrite=1 in ALUWB; Flags unchanged.
- CMP R2,R3 (Funct=010101) with ALUFlags=0100: ALUControl=001, RegWrite never 1, Flags=0100 after EXECUTER.
- After Flags=0100, ADDNE (Cond=0001, Funct=101000): 4 cycles, RegWrite=0 throughout; ADDEQ same path with RegWrite=1.
- LDR (Op=01, Funct=100001): 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 + RegWrite in MEMWB; STR (Funct=100000): MemWrite=1 only in cycle 4.
- B with Cond=1110: 3 cycles, PCWrite=1 in FETCH and BRANCH; ADD with Rd=1111 asserts PCWrite in ALUWB.
- EOR (cmd 0001): EXT_OPS=0 → illegal=1 in DECODE, back to FETCH, no writes; EXT_OPS=1 → ALUControl=100. Assert reset_n=0 in MEMREAD: state FETCH, all enables 0.
